// File: rtl/prbs_pkg.sv
// Shared PRBS31 definitions used by both the generator and the checker.
package prbs_pkg;

  localparam int PRBS31_LEN = 31;
  localparam int TAP_A      = 30;
  localparam int TAP_B      = 27;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  // Next bit of x^31 + x^28 + 1, with the newest bit held in s[0].
  function automatic logic prbs31_next(input logic [PRBS31_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats the increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/prbs31_checker.sv
// Self-synchronising serial PRBS31 checker: hunt/verify/lock FSM, blockwise
// loss-of-lock window and saturating BER counters.
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_THRESH = 64,
  parameter int LOSS_WIN    = 32,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [BIT_W-1:0] bit_cnt,
  output logic [1:0]       state
);

  localparam int FILL_W  = $clog2(PRBS31_LEN + 1);
  localparam int MATCH_W = 8;
  localparam int WIN_W   = $clog2(LOSS_WIN + 1);
  localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

  prbs_state_t               cur;
  logic [PRBS31_LEN-1:0]     sr;
  logic [FILL_W-1:0]         fill;
  logic [MATCH_W-1:0]        match;
  logic [WIN_W-1:0]          win_n;
  logic [WERR_W-1:0]         win_e;

  logic                      exp_bit;
  logic                      miss;
  logic                      chk_bit;
  logic                      err_hit;
  logic [PRBS31_LEN-1:0]     sr_din;

  assign exp_bit = prbs31_next(sr);
  assign miss    = din ^ exp_bit;
  assign chk_bit = en && (cur == LOCKED);
  assign err_hit = chk_bit && miss;
  assign sr_din  = {sr[PRBS31_LEN-2:0], din};
  assign state   = cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= HUNT;
      sr      <= '0;
      fill    <= '0;
      match   <= '0;
      win_n   <= '0;
      win_e   <= '0;
      locked  <= 1'b0;
      bit_err <= 1'b0;
    end else begin
      bit_err <= err_hit;
      if (en) begin
        case (cur)
          HUNT: begin
            sr <= sr_din;
            if (fill == FILL_W'(PRBS31_LEN - 1)) begin
              fill <= '0;
              // An all-zero fill is the LFSR lock-up state; keep hunting.
              if (sr_din != '0) begin
                cur   <= VERIFY;
                match <= '0;
              end
            end else begin
              fill <= fill + 1'b1;
            end
          end
          VERIFY: begin
            sr <= sr_din;
            if (miss) begin
              cur   <= HUNT;
              fill  <= '0;
              match <= '0;
            end else if (match == MATCH_W'(LOCK_THRESH - 1)) begin
              cur    <= LOCKED;
              locked <= 1'b1;
              win_n  <= '0;
              win_e  <= '0;
            end else begin
              match <= match + 1'b1;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so one corrupted bit costs one error.
            sr <= {sr[PRBS31_LEN-2:0], exp_bit};
            if (miss && win_e == WERR_W'(LOSS_THRESH - 1)) begin
              cur    <= HUNT;
              locked <= 1'b0;
              fill   <= '0;
              match  <= '0;
            end else if (win_n == WIN_W'(LOSS_WIN - 1)) begin
              win_n <= '0;
              win_e <= '0;
            end else begin
              win_n <= win_n + 1'b1;
              win_e <= win_e + WERR_W'(miss);
            end
          end
          default: begin
            cur    <= HUNT;
            locked <= 1'b0;
            fill   <= '0;
            match  <= '0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_hit),
    .clr   (clr),
    .cnt   (err_cnt)
  );

  sat_counter #(.W(BIT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (chk_bit),
    .clr   (clr),
    .cnt   (bit_cnt)
  );

endmodule

// File: tb/tb_prbs31_checker.sv
// Bench for prbs31_checker: behavioural reference model, per-cycle compare and
// directed plus randomized stimulus.
module tb_prbs31_checker;

  localparam int LOCK_THRESH = 64;
  localparam int LOSS_WIN    = 32;
  localparam int LOSS_THRESH = 8;
  localparam int ERR_W       = 4;
  localparam int BIT_W       = 32;
  localparam longint ERR_MAX = (64'd1 << ERR_W) - 1;
  localparam longint BIT_MAX = (64'd1 << BIT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             din = 1'b0;
  logic             clr = 1'b0;
  logic             locked;
  logic             bit_err;
  logic [ERR_W-1:0] err_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [1:0]       state;

  prbs31_checker #(
    .LOCK_THRESH (LOCK_THRESH),
    .LOSS_WIN    (LOSS_WIN),
    .LOSS_THRESH (LOSS_THRESH),
    .ERR_W       (ERR_W),
    .BIT_W       (BIT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .din     (din),
    .clr     (clr),
    .locked  (locked),
    .bit_err (bit_err),
    .err_cnt (err_cnt),
    .bit_cnt (bit_cnt),
    .state   (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: history kept as a queue, oldest bit first.
  int     m_state, m_fill, m_match, m_win_n, m_win_e;
  longint m_err, m_bit;
  bit     m_berr, m_locked;
  bit     q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_fill = 0; m_match = 0; m_win_n = 0; m_win_e = 0;
      m_err = 0; m_bit = 0; m_berr = 0; m_locked = 0;
      q.delete();
    end else begin
      bit e, any;
      m_berr = 0;
      if (en) begin
        case (m_state)
          0: begin
            q.push_back(din);
            if (q.size() > 31) void'(q.pop_front());
            m_fill++;
            if (m_fill == 31) begin
              m_fill = 0;
              any = 0;
              foreach (q[i]) any |= q[i];
              if (any) begin m_state = 1; m_match = 0; end
            end
          end
          1: begin
            e = q[0] ^ q[3];
            q.push_back(din); void'(q.pop_front());
            if (din != e) begin m_state = 0; m_fill = 0; m_match = 0; end
            else begin
              m_match++;
              if (m_match == LOCK_THRESH) begin m_state = 2; m_win_n = 0; m_win_e = 0; end
            end
          end
          default: begin
            e = q[0] ^ q[3];
            q.push_back(e); void'(q.pop_front());
            if (m_bit < BIT_MAX) m_bit++;
            m_win_n++;
            if (din != e) begin
              if (m_err < ERR_MAX) m_err++;
              m_berr = 1;
              m_win_e++;
            end
            if (m_win_e >= LOSS_THRESH) begin m_state = 0; m_fill = 0; m_match = 0; end
            else if (m_win_n == LOSS_WIN) begin m_win_n = 0; m_win_e = 0; end
          end
        endcase
      end
      if (clr) begin m_err = 0; m_bit = 0; end
      m_locked = (m_state == 2);
    end
  end

  always @(negedge clk) begin
    chk("cyc_locked",  locked,  m_locked);
    chk("cyc_bit_err", bit_err, m_berr);
    chk("cyc_err_cnt", err_cnt, m_err);
    chk("cyc_bit_cnt", bit_cnt, m_bit);
    chk("cyc_state",   state,   m_state);
  end

  // Clean PRBS31 source; advances only on valid bits.
  logic [30:0] g = 31'h7FFF_FFFF;

  task automatic cyc(input bit e, input bit flip, input bit c);
    bit b;
    b   = g[30] ^ g[27];
    en  = e;
    clr = c;
    din = e ? (b ^ flip) : 1'($urandom);
    @(posedge clk); #1;
    if (e) g = {g[29:0], b};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic lock_seq(input string name);
    for (int i = 1; i <= 95; i++) begin
      cyc(1, 0, 0);
      if (i == 94) chk({name, "_pre94"}, locked, 0);
      if (i == 95) chk({name, "_at95"},  locked, 1);
    end
  endtask

  task automatic align_win();
    for (int k = 0; k < LOSS_WIN && m_win_n != 0; k++) cyc(1, 0, 0);
  endtask

  initial begin
    int bad;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_bit_err", bit_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_state", state, 0);
    rst_n = 1'b1;

    // Clean lock, then 1000 checked bits
    lock_seq("lock1");
    repeat (1000) cyc(1, 0, 0);
    chk("clean_bit_cnt", bit_cnt, 1000);
    chk("clean_err_cnt", err_cnt, 0);

    // clr beats a simultaneous increment; single flip counted once
    cyc(1, 0, 1);
    chk("clr_bit_cnt", bit_cnt, 0);
    cyc(1, 1, 0);
    chk("flip_bit_err", bit_err, 1);
    chk("flip_err_cnt", err_cnt, 1);
    cyc(1, 0, 0);
    chk("flip_pulse_end", bit_err, 0);
    repeat (100) cyc(1, 0, 0);
    chk("flip_err_once", err_cnt, 1);
    chk("flip_still_locked", locked, 1);

    // 8 errors in one window drop lock
    cyc(1, 0, 1);
    align_win();
    for (int j = 0; j <= 14; j++) begin
      cyc(1, (j % 2) == 0, 0);
      if (j == 12) chk("loss_7th_locked", locked, 1);
      if (j == 14) begin
        chk("loss_8th_locked", locked, 0);
        chk("loss_8th_bit_err", bit_err, 1);
        chk("loss_err_cnt", err_cnt, 8);
        chk("loss_state", state, 0);
      end
    end
    lock_seq("relock");

    // 6 errors per window over 3 windows: stays locked, err_cnt saturates
    cyc(1, 0, 1);
    align_win();
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < LOSS_WIN; k++) cyc(1, k < 6, 0);
    chk("sat_locked", locked, 1);
    chk("sat_err_cnt", err_cnt, ERR_MAX);

    // clr coincident with an error
    cyc(1, 1, 1);
    chk("clr_err_bit_err", bit_err, 1);
    chk("clr_err_cnt", err_cnt, 0);

    // All-zero input never leaves HUNT
    do_reset();
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      en = 1'b1; din = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
      if (state != 2'd0 || locked) bad++;
    end
    chk("zeros_hunt", bad, 0);

    // en toggling: 95 valid bits over 190 cycles
    do_reset();
    for (int i = 1; i <= 190; i++) begin
      cyc((i % 2) == 0, 0, 0);
      if (i == 189) chk("tog_pre", locked, 0);
      if (i == 190) chk("tog_lock", locked, 1);
    end
    for (int i = 1; i <= 50; i++) cyc((i % 2) == 0, 0, 0);
    chk("tog_bit_cnt", bit_cnt, 25);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit e, f, c;
      e = ($urandom % 4) != 0;
      f = (m_state == 2) ? (($urandom % 30) == 0) :
          (m_state == 1) ? (($urandom % 200) == 0) : 1'b0;
      if (m_state == 2 && ($urandom % 600) == 0) f = 1'b1;
      c = ($urandom % 100) == 0;
      cyc(e, f, c);
    end

    // Asynchronous reset while locked
    for (int i = 0; i < 400 && !locked; i++) cyc(1, 0, 0);
    chk("pre_rst_locked", locked, 1);
    rst_n = 1'b0;
    #2;
    chk("async_locked", locked, 0);
    chk("async_state", state, 0);
    chk("async_bit_cnt", bit_cnt, 0);
    chk("async_err_cnt", err_cnt, 0);
    chk("async_bit_err", bit_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) cyc(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
